// File: rtl/mips_multicycle_controller_if.sv
// Signal bundle between the multicycle MIPS controller and its datapath.
// The datapath side drives the instruction fields and ALU flag; the controller drives every select and enable.
interface mips_multicycle_controller_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [3:0] State;

  modport master (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
    input  ALUSrcB, ALUControl, PCSrc, PCEn, State
  );

  modport slave (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
    output ALUSrcB, ALUControl, PCSrc, PCEn, State
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath with a combinational ALU decoder.
// State-decoded controls are registered from the next state, so they line up with the state register.
module mips_multicycle_controller (
  input logic                         clk,
  input logic                         reset,
  mips_multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  ctrl_t      r_ctrl;
  logic [2:0] w_alu_control;

  // Next-state logic; unknown opcodes fall back to FETCH as a no-op.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEXEC;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Op == OP_SW) begin
          w_next_state = S_MEMWR;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMRD:    w_next_state = S_MEMWB;
      S_EXECUTE:  w_next_state = S_ALUWB;
      S_ADDIEXEC: w_next_state = S_ADDIWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // State register and controls decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= decode_state(S_FETCH);
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= decode_state(w_next_state);
    end
  end

  // ALU decoder: Funct only matters when the FSM requests an R-type operation.
  always_comb begin
    w_alu_control = 3'b010;
    case (r_ctrl.alu_op)
      2'b00: w_alu_control = 3'b010;
      2'b01: w_alu_control = 3'b110;
      2'b10: begin
        case (bus.Funct)
          6'b100000: w_alu_control = 3'b010;
          6'b100010: w_alu_control = 3'b110;
          6'b100100: w_alu_control = 3'b000;
          6'b100101: w_alu_control = 3'b001;
          6'b101010: w_alu_control = 3'b111;
          default:   w_alu_control = 3'b010;
        endcase
      end
      default: w_alu_control = 3'b010;
    endcase
  end

  // Architectural write enables are gated by reset so nothing changes while it is held.
  assign bus.IorD       = r_ctrl.iord;
  assign bus.MemWrite   = r_ctrl.mem_write & ~reset;
  assign bus.IRWrite    = r_ctrl.ir_write & ~reset;
  assign bus.RegDst     = r_ctrl.reg_dst;
  assign bus.MemtoReg   = r_ctrl.mem_to_reg;
  assign bus.RegWrite   = r_ctrl.reg_write & ~reset;
  assign bus.ALUSrcA    = r_ctrl.alu_src_a;
  assign bus.ALUSrcB    = r_ctrl.alu_src_b;
  assign bus.ALUControl = w_alu_control;
  assign bus.PCSrc      = r_ctrl.pc_src;
  assign bus.PCEn       = ~reset & (r_ctrl.pc_write | (r_ctrl.branch & bus.Zero));
  assign bus.State      = r_state;

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Control unit for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and write enable, and generates the 3-bit `ALUControl` code consumed by the ALU. It closes the loop on the ALU's `Zero` flag to resolve `beq`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  6  opcode, instr[31:26], from the instruction register.
- `Funct`  in  6  function field, instr[5:0], from the instruction register.
- `Zero`  in  1  ALU zero flag; 1 when ALUResult == 0.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register load enable.
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  writeback source: 0 = ALUOut, 1 = Data register.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSrc`  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load enable.
- `State`  out  4  current state encoding, for debug and verification.

## Operation
- Moore FSM with 12 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw (100011) and sw (101011); →EXECUTE for R-type (000000); →BRANCH for beq (000100); →ADDIEXEC for addi (001000); →JUMP for j (000010); any other opcode →FETCH (treated as a no-op).
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all →FETCH.
- Per-state outputs (any output not listed is 0; ALUOp is internal):
  - FETCH: ALUSrcB=01, ALUOp=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decoder (combinational):
  - ALUOp 00 → 010; ALUOp 01 → 110.
  - ALUOp 10 → decode Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other Funct → 010.
- PCEn = PCWrite | (Branch & Zero).

## Timing
- State register updates on the rising edge of `clk`. All outputs except `ALUControl` and `PCEn` are decoded from the state only.
- `ALUControl` also depends combinationally on `Funct`; `PCEn` depends combinationally on `Zero`. Both settle within the same cycle.
- Instruction latency in cycles, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Reset:
  - While `reset` = 1 at a rising edge, the state loads FETCH regardless of the current state, including mid-instruction.
  - While `reset` is high, `PCEn`, `IRWrite`, `RegWrite` and `MemWrite` are forced to 0, so no architectural state changes.
  - Other outputs show their FETCH values.
  - The first cycle after `reset` deasserts is a normal FETCH: PCEn=1, IRWrite=1, ALUControl=010.
- `Op` is sampled only in DECODE and MEMADR. `Funct` is used only in EXECUTE. Both are stable because the instruction register loads only in FETCH.

## Test plan
- Reset: hold `reset` for 2 cycles starting in EXECUTE → State=0 and PCEn=IRWrite=RegWrite=MemWrite=0 while reset is high; the first cycle after release shows PCEn=1, IRWrite=1, ALUSrcB=01, ALUControl=010.
- lw: Op=100011 → State sequence 0,1,2,3,4,0; ALUSrcB=10 in state 2; IorD=1 in state 3; MemtoReg=1 and RegWrite=1 in state 4.
- sw: Op=101011 → sequence 0,1,2,5,0; MemWrite=1 for exactly 1 cycle with IorD=1; RegWrite never asserted.
- R-type: Op=000000 with Funct=100010, then 101010, then 111111 → ALUControl in EXECUTE is 110, 111, 010 respectively; RegDst=1 and RegWrite=1 in ALUWB.
- beq: Op=000100 with Zero=1 → PCEn=1, PCSrc=01, ALUControl=110 in BRANCH. Repeat with Zero=0 → PCEn=0. Both return to FETCH after 3 cycles.
- addi, j and illegal opcode:
  - Op=001000 → sequence 0,1,9,10,0 with RegDst=0 and RegWrite=1 in state 10.
  - Op=000010 → sequence 0,1,11,0 with PCSrc=10 and PCEn=1.
  - Op=111111 → sequence 0,1,0 with no write enables asserted in DECODE.
